// File: rtl/d_latch_cell.sv
// d_latch_cell: 1-bit level-sensitive D latch with asynchronous active-low reset.
module d_latch_cell (
   input  logic enable,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic q_not
);
   logic r_q;
   always_latch
      if (!reset_n) r_q <= 1'b0;
      else if (enable) r_q <= d;
   assign q     = r_q;
   assign q_not = ~r_q;
endmodule

// File: rtl/d_latch_rstn.sv
// d_latch_rstn: WIDTH independent D latches sharing one gate and one async active-low reset.
module d_latch_rstn #(
   parameter int WIDTH = 1
) (
   input  logic             enable,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_not
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_latch_cell u_cell (
         .enable  (enable),
         .reset_n (reset_n),
         .d       (d[i]),
         .q       (q[i]),
         .q_not   (q_not[i])
      );
   end
endmodule

// File: tb/tb_d_latch_rstn.sv
// tb_d_latch_rstn: scoreboard bench for 1-bit and 4-bit latch instances driven in lockstep.
`timescale 1us/1ns
module tb_d_latch_rstn;
   typedef struct {
      string      tag;
      logic       e1;
      logic [3:0] e4;
   } exp_t;

   logic       clk = 1'b0;
   logic       enable, reset_n, d1;
   logic [3:0] d4;
   logic       q1, qn1;
   logic [3:0] q4, qn4;
   logic       m1 = 1'bx;
   logic [3:0] m4 = 4'bx;
   exp_t       sb[$];
   event       smp;
   int         checks = 0;
   int         errors = 0;

   always #0.1 clk = ~clk;

   d_latch_rstn u1 (.enable(enable), .reset_n(reset_n), .d(d1), .q(q1), .q_not(qn1));
   d_latch_rstn #(.WIDTH(4)) u4 (.enable(enable), .reset_n(reset_n), .d(d4), .q(q4), .q_not(qn4));

   // Model: reset clears, open gate copies d, closed gate keeps whatever was last copied.
   task automatic apply(input logic rn, input logic en, input logic v1, input logic [3:0] v4);
      enable  = en;
      reset_n = rn;
      d1      = v1;
      d4      = v4;
      if (rn !== 1'b1) begin
         m1 = 1'b0;
         m4 = 4'h0;
      end else if (en) begin
         m1 = v1;
         m4 = v4;
      end
   endtask

   task automatic chk(input string tag);
      sb.push_back('{tag, m1, m4});
      #0.01 -> smp;
   endtask

   task automatic at(input realtime t);
      #(t - $realtime);
   endtask

   task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", tag, got, want, $realtime);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(smp);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, "_q1"},  {3'b0, q1},  {3'b0, e.e1});
            cmp({e.tag, "_qn1"}, {3'b0, qn1}, {3'b0, ~e.e1});
            cmp({e.tag, "_q4"},  q4,  e.e4);
            cmp({e.tag, "_qn4"}, qn4, ~e.e4);
         end
      end
   end

   initial begin
      #5000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       rn, en, v1;
      logic [3:0] v4;
      apply(1'b0, 1'b0, 1'bx, 4'bx);
      chk("rst_dx");
      at(0.2); apply(1'b0, 1'b0, 1'b0, 4'h0); chk("rst_d0");
      at(0.6); chk("rst_hold");
      at(0.7); apply(1'b1, 1'b0, 1'b1, 4'hA); chk("rel_closed");
      at(2.1); chk("closed_hold");
      at(2.2); apply(1'b1, 1'b1, 1'b1, 4'hA); chk("open");
      at(2.5); apply(1'b1, 1'b1, 1'b0, 4'h3); chk("follow0");
      at(2.8); apply(1'b1, 1'b1, 1'b1, 4'hA); chk("follow1");
      at(3.8); apply(1'b1, 1'b0, 1'b0, 4'h0); chk("close_same_step");
      at(4.8); apply(1'b1, 1'b0, 1'b1, 4'hF); chk("closed_ignore");
      at(6.8); apply(1'b1, 1'b1, 1'b0, 4'h0); chk("reopen");
      at(19.9); chk("reopen_hold");
      at(20.0); apply(1'b1, 1'b1, 1'b1, 4'hA); chk("pre_pulse");
      at(20.2); apply(1'b0, 1'b1, 1'b1, 4'hA); chk("mid_open_rst");
      at(20.3); apply(1'b1, 1'b1, 1'b1, 4'hA); chk("rel_open");
      at(20.5); apply(1'b1, 1'b0, 1'b1, 4'hA); chk("hold_a");
      at(20.6); apply(1'b0, 1'b0, 1'b1, 4'hA); chk("mid_hold_rst");
      at(20.7); apply(1'b1, 1'b0, 1'b1, 4'hA); chk("no_restore");
      repeat (300) begin
         @(posedge clk);
         rn = ($urandom_range(0, 7) != 0);
         en = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         v4 = 4'($urandom_range(0, 15));
         apply(rn, en, v1, v4);
         @(negedge clk);
         chk("rand");
      end
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/d_latch_rstn.md
D_LATCH_RSTN -- requirements
Module: d_latch_rstn

Interface
REQ-001 SHALL declare parameter WIDTH, default 1, meaning the number of independent latch bits.
REQ-002 SHALL declare ports in this order:
- enable  input  WIDTH-shared 1 bit  level-sensitive gate; the block's single clock-class (timing) input; transparent when high.
- reset_n  input  1 bit  reset; asynchronous and active-low.
- d  input  WIDTH  data input.
- q  output  WIDTH  latched data.
- q_not  output  WIDTH  bitwise complement of q.
REQ-003 SHALL use enable as the only timing input; no other clock exists in the block.
REQ-004 SHALL use reset_n as the only reset; it is asynchronous and active-low.

Function
REQ-005 SHALL force q = all-zeros and q_not = all-ones while reset_n = 0, independent of enable and d, including d = X/Z.
REQ-006 SHALL make q follow d combinationally (transparent mode) while reset_n = 1 and enable = 1; no clock-cycle latency.
REQ-007 SHALL hold q unchanged while reset_n = 1 and enable = 0; d changes are ignored.
REQ-008 SHALL set the held value to the value d had immediately before enable fell.
- If d changes in the same time step as enable falls, the pre-change d is held.
REQ-009 SHALL keep q_not = ~q at all times after reset, with no extra delay.
- q and q_not are never equal, except transiently at time zero before the first reset.
REQ-010 SHALL make q take d immediately on reset_n release (0->1) while enable = 1.
REQ-011 SHALL make q stay 0 on reset_n release while enable = 0, until enable next rises.
REQ-012 SHALL give reset_n priority over enable when both change in the same time step.
REQ-013 SHALL treat each bit independently for WIDTH > 1; enable and reset_n are common to all bits.
REQ-014 SHALL leave q undefined (X) before the first reset assertion if reset_n and enable have not yet determined it; no power-up value is guaranteed.

Reset
REQ-015 SHALL take effect with no dependence on enable; reset is asynchronous.
REQ-016 SHALL set reset values q = 0 and q_not = 1 for every bit.
REQ-017 SHALL clear the held state on reset assertion mid-hold or mid-transparency; the old value is not restored after release.

Structure
REQ-018 SHALL be intentionally latch-inferred RTL (level-sensitive always block or equivalent); synthesis latch warnings are expected and waived for this block only.
REQ-019 SHALL place no shared package; the only constant is the WIDTH parameter.
REQ-020 SHALL use one sub-module, d_latch_cell: a 1-bit latch with async active-low reset and ports enable, reset_n, d, q, q_not.
- The top instantiates WIDTH copies via generate.
REQ-021 SHALL contain no flip-flops, no combinational feedback outside the latch cell, and no initial blocks.

Verification (timescale 1us/1ns; WIDTH = 1 unless stated)
REQ-022 SHALL cover reset dominance: reset_n = 0, enable = 0, d = X then 0 at t = 0.2 -> q = 0, q_not = 1 throughout 0-0.7us.
REQ-023 SHALL cover release while closed: at t = 0.7 set reset_n = 1, d = 1, enable = 0 -> q stays 0 until t = 2.2.
REQ-024 SHALL cover transparency:
- At t = 2.2 set enable = 1 -> q = 1.
- d = 0 at 2.5 -> q = 0.
- d = 1 at 2.8 -> q = 1; q_not is always the inverse.
REQ-025 SHALL cover simultaneous close and data change: at t = 3.8 set enable = 0 and d = 0 together -> q holds 1. Then d = 1 at 4.8 -> q still 1.
REQ-026 SHALL cover reopen: at t = 6.8 set enable = 1, d = 0 -> q = 0, q_not = 1 immediately; hold until the 20us end.
REQ-027 SHALL cover mid-transparency reset: enable = 1, d = 1, q = 1, then pulse reset_n low for 0.1us -> q = 0 during the pulse, q = 1 immediately after release.
- Repeat with WIDTH = 4, d = 4'hA -> q = 4'hA, q_not = 4'h5.
